// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 executes and holds one result. Stage 2 is the output register.
// Optional build macro ALU_MUL_EN adds an iterative shift-add multiplier for op 7.
// That multiplier stalls stage 1 for WIDTH clocks.
// Without ALU_MUL_EN, op 7 completes in one cycle with out=0 and err=1.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             zero,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
      OP_OR  = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6, OP_MUL = 3'd7
   } op_t;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_READY, S_MUL} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_READY} state_t;
`endif

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_s1_res;
   logic             r_s1_carry, r_s1_err;
   logic [WIDTH-1:0] r_s2_out;
   logic             r_s2_carry, r_s2_zero, r_s2_err, r_s2_valid;

   logic [WIDTH-1:0] w_res;
   logic             w_carry, w_err;
   logic [WIDTH:0]   w_sum;
   logic             w_accept, w_advance;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] r_mul_a, r_acc, w_acc_next;
   logic [WIDTH-1:0]   r_mul_b;
   logic [SHW-1:0]     r_cnt;
   logic               w_is_mul, w_mul_last;

   assign w_is_mul   = (op_in == OP_MUL);
   assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
   assign w_acc_next = r_acc + (r_mul_b[0] ? r_mul_a : '0);
`endif

   // The stage 1 result moves on when stage 2 is empty or is draining this cycle.
   assign w_advance = (r_state == S_READY) && (!r_s2_valid || out_ready);
   assign in_ready  = (r_state == S_IDLE) || w_advance;
   assign w_accept  = in_valid && in_ready;

   assign out       = r_s2_out;
   assign carry     = r_s2_carry;
   assign zero      = r_s2_zero;
   assign err       = r_s2_err;
   assign out_valid = r_s2_valid;

   // Single-cycle execute of the presented operation.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_res   = '0;
      w_carry = 1'b0;
      w_err   = 1'b0;
      w_sum   = '0;
      case (op_t'(op_in))
         OP_ADD: begin
            w_sum   = {1'b0, a_in} + {1'b0, b_in};
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_sum   = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH+1)'(1);
            w_res   = w_sum[WIDTH-1:0];
            w_carry = (a_in < b_in);
         end
         OP_AND: w_res = a_in & b_in;
         OP_OR:  w_res = a_in | b_in;
         OP_XOR: w_res = a_in ^ b_in;
         OP_SHL: w_res = a_in << b_in[SHW-1:0];
`ifndef ALU_MUL_EN
         OP_MUL: w_err = 1'b1;
`endif
         default: w_res = '0;
      endcase
   end

   // Stage 1 state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Stage 1 next-state: accept, iterate a multiply, or hand off to stage 2.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_READY: begin
            if (w_accept) begin
`ifdef ALU_MUL_EN
               w_state_next = w_is_mul ? S_MUL : S_READY;
`else
               w_state_next = S_READY;
`endif
            end else if (w_advance) begin
               w_state_next = S_IDLE;
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: if (w_mul_last) w_state_next = S_READY;
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   // Stage 1 datapath: capture the executed result, or step the multiplier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_res   <= '0;
         r_s1_carry <= 1'b0;
         r_s1_err   <= 1'b0;
`ifdef ALU_MUL_EN
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
`endif
      end else if (w_accept) begin
         r_s1_res   <= w_res;
         r_s1_carry <= w_carry;
         r_s1_err   <= w_err;
`ifdef ALU_MUL_EN
         r_mul_a    <= {{WIDTH{1'b0}}, a_in};
         r_mul_b    <= b_in;
         r_acc      <= '0;
         r_cnt      <= '0;
      end else if (r_state == S_MUL) begin
         r_acc   <= w_acc_next;
         r_mul_a <= r_mul_a << 1;
         r_mul_b <= r_mul_b >> 1;
         r_cnt   <= r_cnt + SHW'(1);
         if (w_mul_last) begin
            r_s1_res   <= w_acc_next[WIDTH-1:0];
            r_s1_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
         end
`endif
      end
   end

   // Stage 2 output register: load on advance, release once consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_out   <= '0;
         r_s2_carry <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_err   <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (w_advance) begin
         r_s2_out   <= r_s1_res;
         r_s2_carry <= r_s1_carry;
         r_s2_zero  <= (r_s1_res == '0);
         r_s2_err   <= r_s1_err;
         r_s2_valid <= 1'b1;
      end else if (out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand-written sequences for alu_pipe.
// Covers reset, backpressure, multiply latency and randomised streaming.
// The sequences match the build of the design: ALU_MUL_EN defined or not.
module tb_alu_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   op_in;
   logic [W-1:0] a_in, b_in;
   logic         in_valid, in_ready;
   logic [W-1:0] out;
   logic         carry, zero, err, out_valid, out_ready;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_out;
      logic         exp_carry;
      logic         exp_zero;
      logic         exp_err;
   } vec_t;

   vec_t        vecs[$];
   logic [10:0] q_exp[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .op_in(op_in), .a_in(a_in), .b_in(b_in),
      .in_valid(in_valid), .in_ready(in_ready), .out(out), .carry(carry),
      .zero(zero), .err(err), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference result packed as {err, zero, carry, out}.
   function automatic logic [10:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      int         s;
      logic [W-1:0] o;
      logic       c, e;
      o = '0; c = 1'b0; e = 1'b0;
      case (op)
         3'd1: begin s = int'(a) + int'(b); o = W'(s); c = (s > 255); end
         3'd2: begin o = a - b; c = (a < b); end
         3'd3: o = a & b;
         3'd4: o = a | b;
         3'd5: o = a ^ b;
         3'd6: o = a << b[2:0];
`ifdef ALU_MUL_EN
         3'd7: begin s = int'(a) * int'(b); o = W'(s); c = ((s >> 8) != 0); end
`else
         3'd7: e = 1'b1;
`endif
         default: o = '0;
      endcase
      return {e, (o == '0), c, o};
   endfunction

   // One isolated transaction with out_ready=1; checks latency and result.
   task automatic run_vec(input int idx, input vec_t v);
      op_in = v.op; a_in = v.a; b_in = v.b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", idx), out_valid, 0);
      step();
      check($sformatf("vec%0d_valid", idx), out_valid, 1);
      check($sformatf("vec%0d_result", idx), {err, zero, carry, out},
            {v.exp_err, v.exp_zero, v.exp_carry, v.exp_out});
      step();
   endtask

   // Random stream; rand_mode toggles out_ready and in_valid randomly.
   task automatic stream(input int ncyc, input bit rand_mode);
      int   n_acc, n_beats;
      logic acc;
      n_acc = 0; n_beats = 0; acc = 1'b1;
      in_valid = 1'b0;
      for (int c = 0; c < ncyc + 6; c++) begin
         if (c < ncyc) begin
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!in_valid || acc) begin
               in_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
               op_in    = 3'($urandom_range(0, 6));
               a_in     = W'($urandom);
               b_in     = W'($urandom);
            end
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            n_beats++;
            check("stream_no_extra_beat", (q_exp.size() > 0), 1);
            if (q_exp.size() > 0) check("stream_result", {err, zero, carry, out}, q_exp.pop_front());
         end
         if (acc) begin
            q_exp.push_back(model(op_in, a_in, b_in));
            n_acc++;
         end
         step();
      end
      check("stream_no_drop", q_exp.size(), 0);
      if (!rand_mode) begin
         check("stream_accept_every_cycle", n_acc, ncyc);
         check("stream_beats", n_beats, ncyc);
      end
   endtask

   initial begin
      vecs.push_back('{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{3'd2, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{3'd2, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd2, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd4, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd5, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd6, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd6, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{3'd0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0});
`ifndef ALU_MUL_EN
      vecs.push_back('{3'd7, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b1, 1'b1});
`endif

      // Power-on reset.
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op_in = '0; a_in = '0; b_in = '0;
      #3;
      check("reset_outputs", {err, zero, carry, out_valid, out}, 0);
      #9 rst_n = 1'b1;
      step();
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);

      // Vector table.
      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Backpressure: two ops fill the pipe, the third is refused.
      out_ready = 1'b0;
      op_in = 3'd1; a_in = 8'h01; b_in = 8'h01; in_valid = 1'b1;
      #1 check("bp_first_ready", in_ready, 1);
      step();
      op_in = 3'd5; a_in = 8'hF0; b_in = 8'hFF;
      #1 check("bp_second_ready", in_ready, 1);
      step();
      op_in = 3'd4; a_in = 8'h01; b_in = 8'h02;
      #1 check("bp_third_refused", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_hold%0d", i), {out_valid, out}, {1'b1, 8'h02});
         step();
      end
      check("bp_still_refused", in_ready, 0);
      out_ready = 1'b1;
      #1 check("bp_ready_on_consume", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_beat2", {out_valid, out}, {1'b1, 8'h0F});
      step();
      check("bp_beat3", {out_valid, out}, {1'b1, 8'h03});
      step();
      check("bp_drained", out_valid, 0);

      // Reset mid-stream with a result held in stage 2: no stale beat.
      out_ready = 1'b0;
      op_in = 3'd1; a_in = 8'h01; b_in = 8'h01; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("midrst_before", out_valid, 1);
      rst_n = 1'b0;
      #1 check("midrst_cleared", {out_valid, out}, 0);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrst_no_beat%0d", i), out_valid, 0);
         step();
      end

`ifdef ALU_MUL_EN
      // MUL 13*11: stalls WIDTH clocks, result WIDTH+1 edges after accept.
      op_in = 3'd7; a_in = 8'd13; b_in = 8'd11; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= W; i++) begin
         check($sformatf("mul_busy%0d", i), {in_ready, out_valid}, 0);
         step();
      end
      check("mul_not_yet", out_valid, 0);
      step();
      check("mul_13x11", {out_valid, err, zero, carry, out}, {4'b1000, 8'h8F});
      step();
      // MUL 16*16 overflows into the high half.
      op_in = 3'd7; a_in = 8'd16; b_in = 8'd16; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (W) step();
      check("mul_16x16_latency", out_valid, 0);
      step();
      check("mul_16x16", {out_valid, err, zero, carry, out}, {4'b1011, 8'h00});
      step();
      // Reset mid-multiply aborts the op.
      op_in = 3'd7; a_in = 8'd3; b_in = 8'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      check("mulrst_in_ready", in_ready, 1);
      for (int i = 0; i < W + 2; i++) step();
      check("mulrst_no_beat", out_valid, 0);
`endif

      // Streaming: full rate, then random backpressure and bubbles.
      stream(40, 1'b0);
      stream(200, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
